// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit:
// funct3 codes, exception causes, FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } exc_cause_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational legality and alignment check
// for one load/store; illegal beats misaligned.
module lsu_access_check
  import load_store_unit_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic       i_is_store,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_ea_lo,
  output logic       o_fault,
  output logic [1:0] o_cause
);

  logic w_legal;
  logic w_mis;

  assign w_legal = i_is_store
    ? (i_funct3 inside {F3_SB, F3_SH, F3_SW})
    : (i_funct3 inside {F3_LB, F3_LH, F3_LW,
                        F3_LBU, F3_LHU});

  assign w_mis = CHECK_ALIGN &&
    (((i_funct3[1:0] == 2'b01) && i_ea_lo[0]) ||
     ((i_funct3[1:0] == 2'b10) &&
      (i_ea_lo != 2'b00)));

  // fault/cause with illegal funct3 first
  always_comb begin
    o_fault = 1'b0;
    o_cause = CAUSE_NONE;
    if (!w_legal) begin
      o_fault = 1'b1;
      o_cause = CAUSE_ILLEGAL;
    end else if (w_mis) begin
      o_fault = 1'b1;
      o_cause = CAUSE_MISALIGN;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of the memory
// controller: EA, checks, issue, wait, respond.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT     = 15,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_start,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_mode,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic        mem_done,
  input  logic [31:0] mem_read_data,
  input  logic        mem_active,
  output logic        done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam logic [7:0] TMO_LAST =
    8'(TIMEOUT - 1);

  lsu_state_e  r_state;
  logic        r_is_store;
  logic [7:0]  r_cnt;
  logic [31:0] w_ea;
  logic        w_accept;
  logic        w_fault;
  logic [1:0]  w_cause;

  assign w_ea = base + offset;

  // memory controller has no reset: wait
  // for any leftover access to drain
  assign ready = (r_state == S_IDLE) &&
                 !mem_active;

  assign w_accept = req && ready;

  lsu_access_check #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_chk (
    .i_is_store(is_store),
    .i_funct3  (funct3),
    .i_ea_lo   (w_ea[1:0]),
    .o_fault   (w_fault),
    .o_cause   (w_cause)
  );

  // sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_is_store       <= 1'b0;
      r_cnt            <= 8'd0;
      mem_start        <= 1'b0;
      mem_address      <= 32'd0;
      mem_mode         <= 3'd0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= 32'd0;
      done             <= 1'b0;
      wb_we            <= 1'b0;
      wb_rd            <= 5'd0;
      wb_data          <= 32'd0;
      exc              <= 1'b0;
      exc_cause        <= CAUSE_NONE;
      exc_addr         <= 32'd0;
    end else begin
      mem_start <= 1'b0;
      done      <= 1'b0;
      wb_we     <= 1'b0;
      exc       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_store <= is_store;
            wb_rd      <= rd;
            if (w_fault) begin
              r_state   <= S_RESP;
              done      <= 1'b1;
              exc       <= 1'b1;
              exc_cause <= w_cause;
              exc_addr  <= w_ea;
            end else begin
              r_state          <= S_ISSUE;
              mem_start        <= 1'b1;
              mem_address      <= w_ea;
              mem_mode         <= funct3;
              mem_write_data   <= store_data;
              mem_write_enable <= is_store;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_cnt   <= 8'd0;
        end
        S_WAIT: begin
          if (mem_done) begin
            r_state          <= S_RESP;
            done             <= 1'b1;
            mem_write_enable <= 1'b0;
            if (!r_is_store) begin
              wb_data <= mem_read_data;
              wb_we   <= (wb_rd != 5'd0);
            end
          end else if (r_cnt == TMO_LAST) begin
            r_state          <= S_RESP;
            done             <= 1'b1;
            exc              <= 1'b1;
            exc_cause        <= CAUSE_TIMEOUT;
            exc_addr         <= mem_address;
            mem_write_enable <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          exc_cause <= CAUSE_NONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a
// byte-serial memory model behind it.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] base = 32'd0;
  logic [31:0] offset = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        ready;
  logic        mem_start;
  logic [31:0] mem_address;
  logic [2:0]  mem_mode;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_done = 1'b0;
  logic [31:0] mem_read_data = 32'd0;
  logic        mem_active = 1'b0;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc;
  logic [1:0]  exc_cause;
  logic [31:0] exc_addr;

  load_store_unit #(
    .TIMEOUT(TMO),
    .CHECK_ALIGN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .ready(ready), .is_store(is_store),
    .funct3(funct3), .base(base),
    .offset(offset), .store_data(store_data),
    .rd(rd), .mem_start(mem_start),
    .mem_address(mem_address),
    .mem_mode(mem_mode),
    .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data),
    .mem_done(mem_done),
    .mem_read_data(mem_read_data),
    .mem_active(mem_active), .done(done),
    .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .exc(exc),
    .exc_cause(exc_cause),
    .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // memory model: one byte per cycle, done in
  // the last cycle, data sign/zero extended
  logic [7:0] mem [logic [31:0]];
  int rem = 0;
  bit stall = 1'b0;

  function automatic logic [7:0] rdb(
    logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_start && !stall) begin
      int n;
      logic [31:0] v;
      n = (mem_mode[1:0] == 2'b00) ? 1 :
          (mem_mode[1:0] == 2'b01) ? 2 : 4;
      v = 32'd0;
      for (int i = 0; i < n; i++) begin
        if (mem_write_enable)
          mem[mem_address + 32'(i)] =
            mem_write_data[8*i +: 8];
        v[8*i +: 8] = rdb(mem_address + 32'(i));
      end
      if (!mem_mode[2] && n == 1)
        v = {{24{v[7]}}, v[7:0]};
      if (!mem_mode[2] && n == 2)
        v = {{16{v[15]}}, v[15:0]};
      mem_read_data <= v;
      rem        <= n;
      mem_done   <= (n == 1);
      mem_active <= 1'b1;
    end else if (rem > 0) begin
      rem        <= rem - 1;
      mem_done   <= (rem == 2);
      mem_active <= (rem > 1);
    end
  end

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ex;
    logic [1:0]  cause;
    logic [31:0] addr;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  int          n_start = 0;
  logic [31:0] st_addr = 32'd0;
  logic        st_we = 1'b0;
  bit          trk = 1'b0;

  // response and bus-hold monitor
  always @(negedge clk) begin
    if (mem_start) begin
      n_start++;
      st_addr = mem_address;
      st_we   = mem_write_enable;
      trk     = 1'b1;
    end else if (trk && rst_n && mem_active) begin
      check("hold_addr", mem_address, st_addr);
      check("hold_we", 32'(mem_write_enable),
            32'(st_we));
    end
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 32'(cyc - e.acc),
              32'(e.lat));
        check("wb_we", 32'(wb_we), 32'(e.we));
        check("exc", 32'(exc), 32'(e.ex));
        check("exc_cause", 32'(exc_cause),
              32'(e.cause));
        check("resp_we", 32'(mem_write_enable),
              32'd0);
        if (e.we) begin
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", wb_data, e.data);
        end
        if (e.ex)
          check("exc_addr", exc_addr, e.addr);
      end
    end
    if (done || !rst_n) trk = 1'b0;
  end

  task automatic do_op(
    logic st, logic [2:0] f3,
    logic [31:0] b, logic [31:0] o,
    logic [31:0] sd, logic [4:0] r,
    logic we, logic [31:0] data,
    logic ex, logic [1:0] cause, int lat);
    exp_t e;
    int k;
    @(negedge clk);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      check("ready_wait", 32'd0, 32'd1);
      return;
    end
    is_store = st; funct3 = f3;
    base = b; offset = o;
    store_data = sd; rd = r;
    e.we = we; e.rd = r; e.data = data;
    e.ex = ex; e.cause = cause;
    e.addr = b + o; e.lat = lat;
    e.acc = cyc;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    sb.push_back(e);
    k = 0;
    while (sb.size() != 0 && k < lat + 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      check("done_wait", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic check_rst();
    check("rst_ctl",
          {27'd0, mem_start, mem_write_enable,
           done, wb_we, exc}, 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_misc",
          {22'd0, mem_mode, wb_rd, exc_cause},
          32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_excaddr", exc_addr, 32'd0);
  endtask

  initial begin
    int s0;
    int k;
    mem[32'h104] = 8'h78; mem[32'h105] = 8'h56;
    mem[32'h106] = 8'h34; mem[32'h107] = 8'h12;
    mem[32'h200] = 8'h80;
    mem[32'h004] = 8'hEF; mem[32'h005] = 8'hBE;
    mem[32'h006] = 8'hAD; mem[32'h007] = 8'hDE;
    mem[32'h400] = 8'h11; mem[32'h401] = 8'h22;
    mem[32'h402] = 8'h33; mem[32'h403] = 8'h44;

    repeat (3) @(negedge clk);
    check_rst();
    check("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;

    s0 = n_start;
    do_op(1'b0, F3_LW, 32'h100, 32'd4, 32'd0,
          5'd5, 1'b1, 32'h12345678,
          1'b0, 2'd0, 6);
    check("lw_starts", 32'(n_start - s0), 32'd1);
    check("lw_addr", st_addr, 32'h104);
    check("lw_mode", 32'(mem_mode), 32'd2);

    do_op(1'b0, F3_LB, 32'h200, 32'd0, 32'd0,
          5'd6, 1'b1, 32'hFFFFFF80,
          1'b0, 2'd0, 3);
    do_op(1'b0, F3_LBU, 32'h210, 32'hFFFFFFF0,
          32'd0, 5'd7, 1'b1, 32'h00000080,
          1'b0, 2'd0, 3);
    do_op(1'b0, F3_LH, 32'h100, 32'd6, 32'd0,
          5'd8, 1'b1, 32'h00001234,
          1'b0, 2'd0, 4);

    do_op(1'b1, F3_SH, 32'h300, 32'd2,
          32'hAABBCCDD, 5'd0, 1'b0, 32'd0,
          1'b0, 2'd0, 4);
    check("sh_b0", 32'(rdb(32'h302)), 32'hDD);
    check("sh_b1", 32'(rdb(32'h303)), 32'hCC);
    check("sh_b2", 32'(rdb(32'h304)), 32'h00);
    @(negedge clk);
    check("idle_we", 32'(mem_write_enable),
          32'd0);

    s0 = n_start;
    do_op(1'b0, F3_LW, 32'h100, 32'd1, 32'd0,
          5'd5, 1'b0, 32'd0, 1'b1, 2'd1, 1);
    do_op(1'b1, 3'b011, 32'h400, 32'd0,
          32'd0, 5'd0, 1'b0, 32'd0,
          1'b1, 2'd2, 1);
    do_op(1'b1, 3'b011, 32'h400, 32'd1,
          32'd0, 5'd0, 1'b0, 32'd0,
          1'b1, 2'd2, 1);
    do_op(1'b0, 3'b110, 32'h400, 32'd0,
          32'd0, 5'd4, 1'b0, 32'd0,
          1'b1, 2'd2, 1);
    do_op(1'b1, 3'b100, 32'h400, 32'd0,
          32'd0, 5'd0, 1'b0, 32'd0,
          1'b1, 2'd2, 1);
    do_op(1'b0, F3_LHU, 32'h200, 32'd1,
          32'd0, 5'd4, 1'b0, 32'd0,
          1'b1, 2'd1, 1);
    check("fault_nostart", 32'(n_start - s0),
          32'd0);

    do_op(1'b0, F3_LW, 32'hFFFFFFFC, 32'd8,
          32'd0, 5'd9, 1'b1, 32'hDEADBEEF,
          1'b0, 2'd0, 6);
    do_op(1'b0, F3_LW, 32'h104, 32'd0, 32'd0,
          5'd0, 1'b0, 32'd0, 1'b0, 2'd0, 6);

    stall = 1'b1;
    do_op(1'b0, F3_LW, 32'h104, 32'd0, 32'd0,
          5'd3, 1'b0, 32'd0, 1'b1, 2'd3,
          TMO + 2);
    stall = 1'b0;
    do_op(1'b1, F3_SB, 32'h500, 32'd0,
          32'h0000005A, 5'd0, 1'b0, 32'd0,
          1'b0, 2'd0, 3);
    check("sb_b0", 32'(rdb(32'h500)), 32'h5A);

    @(negedge clk);
    k = 0;
    while (!ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    is_store = 1'b0; funct3 = F3_LW;
    base = 32'h400; offset = 32'd0; rd = 5'd10;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_active", 32'(mem_active), 32'd1);
    rst_n = 1'b0;
    #1;
    check_rst();
    check("mid_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_start;
    req = 1'b1;
    @(negedge clk);
    check("drain_ready", 32'(ready), 32'd0);
    req = 1'b0;
    k = 0;
    while (mem_active && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain_end", 32'(mem_active), 32'd0);
    check("post_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    check("stale_nostart", 32'(n_start - s0),
          32'd0);
    check("stale_nodone", 32'(done), 32'd0);

    do_op(1'b0, F3_LB, 32'h200, 32'd0, 32'd0,
          5'd11, 1'b1, 32'hFFFFFF80,
          1'b0, 2'd0, 3);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequencing stage directly upstream of memory_control_synth. Accepts one decoded RV32I load/store from execute and forms the effective address. Checks funct3 legality and alignment, then drives memory_control_synth's start/address/mode/write_enable/write_data and holds them stable for the whole access. Returns load data to writeback, or raises a precise exception instead of touching memory.

Parameters:
TIMEOUT, 15, max cycles waiting in WAIT for mem_done before a bus-timeout exception (1..255)
CHECK_ALIGN, 1, 1 = misaligned half/word raises exception; 0 = access issued unaligned

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req  in  1  execute presents an op; accepted on a posedge where req && ready
ready  out  1  high only in IDLE with mem_active low
is_store  in  1  1 = store (SB/SH/SW), 0 = load
funct3  in  3  RV32I load/store funct3
base  in  32  rs1 value
offset  in  32  sign-extended immediate
store_data  in  32  rs2 value
rd  in  5  load destination register
mem_start  out  1  to memory_control_synth.start
mem_address  out  32  to .address
mem_mode  out  3  to .mode (latched funct3)
mem_write_enable  out  1  to .write_enable
mem_write_data  out  32  to .write_data
mem_done  in  1  from .done
mem_read_data  in  32  from .read_data
mem_active  in  1  from .active
done  out  1  one-cycle completion pulse (success or exception)
wb_we  out  1  with done: write wb_data to wb_rd
wb_rd  out  5  latched rd
wb_data  out  32  load result, already sign/zero extended by memory_control_synth
exc  out  1  with done: operation faulted, no writeback
exc_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout
exc_addr  out  32  effective address of faulting op

Behaviour:
- Reset, asynchronous: state IDLE. ready=1 once mem_active low. mem_start, mem_write_enable, done, wb_we and exc are 0. mem_address, mem_mode, mem_write_data, wb_rd, wb_data, exc_cause and exc_addr are 0.
- Effective address ea = base + offset, mod 2^32; wrap-around is legal, no fault.
- Legal funct3: loads 000,001,010,100,101; stores 000,001,010. Anything else is illegal.
- Alignment: funct3[1:0]=01 needs ea[0]=0; =10 needs ea[1:0]=00. Byte ops are always aligned. Illegal funct3 takes priority over misalignment.
- IDLE: on accept, latch is_store, funct3, ea, store_data and rd.
  - Fault: go to RESP with exc set and no memory access.
  - No fault: go to ISSUE.
- ISSUE (1 cycle): mem_start=1, mem_address=ea, mem_mode=funct3, mem_write_data=store_data, mem_write_enable=is_store. Next state WAIT.
- WAIT: mem_start=0. mem_address, mem_mode, mem_write_data and mem_write_enable are held unchanged, because memory_control_synth samples them live every cycle. Timeout counter counts up.
  - mem_done: capture mem_read_data (loads) and go to RESP.
  - Counter reaches TIMEOUT first: go to RESP with cause 3.
- RESP (1 cycle): done=1.
  - wb_we=1 only for a successful load with rd!=0.
  - exc=1 with cause on a fault.
  - mem_write_enable=0. Next state IDLE; ready is low in RESP.
- mem_write_enable is 0 in every state except ISSUE/WAIT of a store. Prevents stray writes.
- Latency, successful access, accept edge to done visible: byte 3 edges, half 4, word 6. Fault: done visible 1 edge after accept.
- mem_done outside WAIT is ignored. Covers a leftover completion after reset mid-access, since memory_control_synth has no reset.
- Reset mid-access: immediate return to IDLE, all outputs to reset values, ready held low until mem_active falls.
- req while not ready: ignored; execute must hold req.

Decomposition:
- arch_defines.v gains:
  - funct3 codes: LB, LH, LW, LBU, LHU, SB, SH, SW
  - exception cause codes
  - LSU state encoding: IDLE, ISSUE, WAIT, RESP
- One combinational sub-module, lsu_access_check: inputs is_store, funct3, ea[1:0], CHECK_ALIGN; outputs fault and cause.
- Sequencing FSM, timeout counter and latches live in load_store_unit.

Test Plan:
- LW, base=0x100, offset=4, mem bytes [0x104..0x107]=78 56 34 12 -> mem_start one cycle with mem_address=0x104, mode=010; done 6 edges after accept; wb_we=1, wb_data=0x12345678.
- LB then LBU at 0x200 holding 0x80 -> wb_data=0xFFFFFF80 then 0x00000080, done 3 edges after accept.
- SH store_data=0xAABBCCDD to 0x302 -> bytes 0x302=DD, 0x303=CC; done with wb_we=0; mem_write_enable=0 in RESP and IDLE.
- LW at 0x101 (CHECK_ALIGN=1) -> done 1 edge after accept, exc=1, cause=1, exc_addr=0x101, mem_start never asserted. funct3=011 store -> cause=2.
- mem_done held low (stub) -> exc cause=3 after TIMEOUT=15 cycles in WAIT; next req accepted normally.
- rst_n low during WAIT of a LW, then released -> outputs at reset values; stale mem_done ignored; ready only after mem_active=0.
